// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: FSM states and access-size codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_READ  = 2'd1,
    LSU_WRITE = 2'd2,
    LSU_RESP  = 2'd3
  } lsu_state_e;

  localparam logic LSU_SIZE_BYTE = 1'b0;
  localparam logic LSU_SIZE_HALF = 1'b1;

endpackage

// File: rtl/load_store_unit.sv
// Initiator side of the byte-wide data-memory port; sequences Rm/Wm/address/RegVal.
// LSU_WORD16_EN enables halfword (two-byte) accesses; otherwise every access is one byte.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic                req_size,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [2*DATA_W-1:0] rsp_rdata,
  output logic                busy,
  output logic                Rm,
  output logic                Wm,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   RegVal,
  input  logic [DATA_W-1:0]   Data_out
);

  lsu_state_e          state_q, state_d;
  logic                idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_lo_q, wdata_lo_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [2*DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                rm_q, rm_d;
  logic                wm_q, wm_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   regval_q, regval_d;
  logic                last;
  logic [DATA_W-1:0]   wdata_hi_q;

`ifdef LSU_WORD16_EN
  logic                size_q, size_d;
  logic [DATA_W-1:0]   wdata_hi_d;

  assign last = (size_q == LSU_SIZE_BYTE) || idx_q;
`else
  logic unused_hi;

  assign last       = 1'b1;
  assign wdata_hi_q = '0;
  assign unused_hi  = ^{req_size, req_wdata[2*DATA_W-1:DATA_W]};
`endif

  // Next-cycle outputs are computed here so every port comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    wdata_lo_d  = wdata_lo_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rm_d        = 1'b0;
    wm_d        = 1'b0;
    address_d   = address_q;
    regval_d    = regval_q;
`ifdef LSU_WORD16_EN
    size_d      = size_q;
    wdata_hi_d  = wdata_hi_q;
`endif
    unique case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          idx_d      = 1'b0;
          addr_d     = req_addr;
          wdata_lo_d = req_wdata[DATA_W-1:0];
          address_d  = req_addr;
`ifdef LSU_WORD16_EN
          size_d     = req_size;
          wdata_hi_d = req_wdata[2*DATA_W-1:DATA_W];
`endif
          if (req_write) begin
            state_d  = LSU_WRITE;
            wm_d     = 1'b1;
            regval_d = req_wdata[DATA_W-1:0];
          end else begin
            state_d     = LSU_READ;
            rm_d        = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      LSU_WRITE: begin
        if (last) begin
          state_d     = LSU_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          idx_d     = 1'b1;
          wm_d      = 1'b1;
          address_d = addr_q + ADDR_W'(1);
          regval_d  = wdata_hi_q;
        end
      end
      LSU_READ: begin
        if (idx_q) rsp_rdata_d[DATA_W +: DATA_W] = Data_out;
        else       rsp_rdata_d[0 +: DATA_W]      = Data_out;
        if (last) begin
          state_d     = LSU_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          idx_d     = 1'b1;
          rm_d      = 1'b1;
          address_d = addr_q + ADDR_W'(1);
        end
      end
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= LSU_IDLE;
      idx_q       <= 1'b0;
      addr_q      <= '0;
      wdata_lo_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rm_q        <= 1'b0;
      wm_q        <= 1'b0;
      address_q   <= '0;
      regval_q    <= '0;
`ifdef LSU_WORD16_EN
      size_q      <= LSU_SIZE_BYTE;
      wdata_hi_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      wdata_lo_q  <= wdata_lo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rm_q        <= rm_d;
      wm_q        <= wm_d;
      address_q   <= address_d;
      regval_q    <= regval_d;
`ifdef LSU_WORD16_EN
      size_q      <= size_d;
      wdata_hi_q  <= wdata_hi_d;
`endif
    end
  end

  assign req_ready = (state_q == LSU_IDLE);
  assign busy      = (state_q != LSU_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign Rm        = rm_q;
  assign Wm        = wm_q;
  assign address   = address_q;
  assign RegVal    = regval_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a negedge-committing byte memory model.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_size  = 1'b0;
  logic [7:0]  req_addr  = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic        Rm;
  logic        Wm;
  logic [7:0]  address;
  logic [7:0]  RegVal;
  logic [7:0]  Data_out;

  logic [7:0]  mem [256] = '{default: 8'h00};
  logic        tb_we = 1'b0;
  logic [7:0]  tb_wa = '0;
  logic [7:0]  tb_wd = '0;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [15:0] exp_q [$];
  logic [15:0] last_rd = '0;

  load_store_unit #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .Rm(Rm), .Wm(Wm), .address(address), .RegVal(RegVal), .Data_out(Data_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (Wm) mem[address] <= RegVal;
    else if (tb_we) mem[tb_wa] <= tb_wd;
  end
  assign Data_out = mem[address];

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(posedge clock);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(negedge clock);
    #1 tb_we = 1'b0;
  endtask

  function automatic logic [15:0] load_model(input logic s, input logic [7:0] a);
    logic [7:0] a1;
    a1 = a + 8'd1;
`ifdef LSU_WORD16_EN
    if (s) return {mem[a1], mem[a]};
`endif
    return {8'h00, mem[a]};
  endfunction

  // Presents one request, returns just after the accepting edge with its cycle index.
  task automatic send(input logic w, input logic s, input logic [7:0] a,
                      input logic [15:0] d, output int t0);
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_size = s; req_addr = a; req_wdata = d;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clock);
    @(posedge clock);
    #1;
    t0 = cyc;
    req_valid = 1'b0;
    if (!w) last_rd = load_model(s, a);
    exp_q.push_back(last_rd);
  endtask

  task automatic wait_rsp(input string name, input int t0, input int lat,
                          input int acc, input logic is_wr);
    int rm_n = 0;
    int wm_n = 0;
    int tr = 0;
    bit got = 0;
    logic [15:0] e;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clock);
      if (Rm && Wm) begin
        total++; bad++;
        $display("FAIL %s_exclusive Rm=%b Wm=%b required not both high", name, Rm, Wm);
      end
      if (Rm) rm_n++;
      if (Wm) wm_n++;
      if (rsp_valid) begin got = 1; tr = cyc; end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s_timeout rsp_valid=0 required 1 within 12 cycles", name);
      return;
    end
    total++;
    if (tr - t0 !== lat) begin
      bad++; $display("FAIL %s_latency got=%0d required=%0d", name, tr - t0, lat);
    end
    total++;
    if ((is_wr ? wm_n : rm_n) !== acc || (is_wr ? rm_n : wm_n) !== 0) begin
      bad++; $display("FAIL %s_access rm=%0d wm=%0d required %0d on %s", name, rm_n, wm_n, acc,
                      is_wr ? "Wm" : "Rm");
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++; $display("FAIL %s_unexpected_rsp rdata=%h required no response", name, rsp_rdata);
    end else begin
      e = exp_q.pop_front();
      if (rsp_rdata !== e) begin
        bad++; $display("FAIL %s_rdata got=%h required=%h", name, rsp_rdata, e);
      end
    end
    @(negedge clock);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL %s_pulse rsp_valid=%b req_ready=%b required 0/1", name, rsp_valid,
                      req_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #2;
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, busy, Rm, Wm, address, RegVal} !==
        {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      bad++;
      $display("FAIL reset_values ready=%b rv=%b rd=%h busy=%b Rm=%b Wm=%b addr=%h rv8=%h required 1 0 0000 0 0 0 00 00",
               req_ready, rsp_valid, rsp_rdata, busy, Rm, Wm, address, RegVal);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_byte;
    int t0;
    send(1'b1, 1'b0, 8'h10, 16'h12A5, t0);
    total++;
    if (Wm !== 1'b1 || Rm !== 1'b0 || address !== 8'h10 || RegVal !== 8'hA5 || busy !== 1'b1) begin
      bad++; $display("FAIL byte_store_bus Wm=%b Rm=%b addr=%h RegVal=%h busy=%b required 1 0 10 a5 1",
                      Wm, Rm, address, RegVal, busy);
    end
    wait_rsp("byte_store", t0, 1, 1, 1'b1);
    total++;
    if (mem[8'h10] !== 8'hA5) begin
      bad++; $display("FAIL byte_store_mem got=%h required=a5", mem[8'h10]);
    end
    send(1'b0, 1'b0, 8'h10, 16'h0000, t0);
    total++;
    if (Rm !== 1'b1 || address !== 8'h10) begin
      bad++; $display("FAIL byte_load_bus Rm=%b addr=%h required 1 10", Rm, address);
    end
    wait_rsp("byte_load", t0, 1, 1, 1'b0);
    total++;
    if (rsp_rdata !== 16'h00A5) begin
      bad++; $display("FAIL byte_load_value got=%h required=00a5", rsp_rdata);
    end
  endtask

  task automatic test_halfword;
    int t0;
    poke(8'h00, 8'h33);
    poke(8'h20, 8'h5C);
    poke(8'h21, 8'h99);
`ifdef LSU_WORD16_EN
    send(1'b1, 1'b1, 8'hFF, 16'hBEEF, t0);
    wait_rsp("half_store", t0, 2, 2, 1'b1);
    total++;
    if (mem[8'hFF] !== 8'hEF || mem[8'h00] !== 8'hBE) begin
      bad++; $display("FAIL half_store_wrap mem[ff]=%h mem[00]=%h required ef be", mem[8'hFF], mem[8'h00]);
    end
    send(1'b0, 1'b1, 8'hFF, 16'h0000, t0);
    wait_rsp("half_load", t0, 2, 2, 1'b0);
    total++;
    if (rsp_rdata !== 16'hBEEF) begin
      bad++; $display("FAIL half_load_value got=%h required=beef", rsp_rdata);
    end
    send(1'b0, 1'b1, 8'h20, 16'h0000, t0);
    wait_rsp("half_load_20", t0, 2, 2, 1'b0);
`else
    send(1'b1, 1'b1, 8'hFF, 16'hBEEF, t0);
    wait_rsp("half_store_ignored", t0, 1, 1, 1'b1);
    total++;
    if (mem[8'hFF] !== 8'hEF || mem[8'h00] !== 8'h33) begin
      bad++; $display("FAIL half_store_ignored_mem mem[ff]=%h mem[00]=%h required ef 33", mem[8'hFF], mem[8'h00]);
    end
    send(1'b0, 1'b1, 8'h20, 16'h0000, t0);
    wait_rsp("half_load_ignored", t0, 1, 1, 1'b0);
    total++;
    if (rsp_rdata !== 16'h005C) begin
      bad++; $display("FAIL half_load_ignored_value got=%h required=005c", rsp_rdata);
    end
`endif
  endtask

  task automatic test_back_to_back;
    int acc [$];
    logic [15:0] e;
    last_rd = load_model(1'b0, 8'h10);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_size = 1'b0; req_addr = 8'h10;
    for (int i = 0; i < 22; i++) begin
      if (i < 15 && req_ready) begin
        acc.push_back(cyc + 1);
        exp_q.push_back(last_rd);
      end
      if (Rm && Wm) begin
        total++; bad++; $display("FAIL b2b_exclusive Rm=%b Wm=%b required not both high", Rm, Wm);
      end
      if (rsp_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_unexpected_rsp rdata=%h required no response", rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          if (rsp_rdata !== e) begin
            bad++; $display("FAIL b2b_rdata got=%h required=%h", rsp_rdata, e);
          end
        end
      end
      @(negedge clock);
      if (i == 14) req_valid = 1'b0;
    end
    total++;
    if (acc.size() !== 5) begin
      bad++; $display("FAIL b2b_accept_count got=%0d required=5", acc.size());
    end
    for (int i = 1; i < acc.size(); i++) begin
      total++;
      if (acc[i] - acc[i-1] !== 3) begin
        bad++; $display("FAIL b2b_interval got=%0d required=3", acc[i] - acc[i-1]);
      end
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL b2b_missing_rsp outstanding=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_write;
    int t0;
    poke(8'h40, 8'h11);
    send(1'b1, 1'b0, 8'h40, 16'h0077, t0);
    void'(exp_q.pop_back());
    reset = 1'b1;
    last_rd = '0;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, busy, Rm, Wm, address, RegVal} !==
        {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      bad++;
      $display("FAIL midreset_values ready=%b rv=%b rd=%h busy=%b Rm=%b Wm=%b addr=%h rv8=%h required 1 0 0000 0 0 0 00 00",
               req_ready, rsp_valid, rsp_rdata, busy, Rm, Wm, address, RegVal);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++; $display("FAIL midreset_no_rsp rsp_valid=%b required=0", rsp_valid);
      end
    end
    total++;
    if (mem[8'h40] !== 8'h11) begin
      bad++; $display("FAIL midreset_mem got=%h required=11", mem[8'h40]);
    end
    send(1'b0, 1'b0, 8'h40, 16'h0000, t0);
    wait_rsp("midreset_readback", t0, 1, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_byte();
    test_halfword();
    test_back_to_back();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required completion earlier", $time);
    $fatal(1);
  end

endmodule
